// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader_pkg
//  Description : Shared constants and helpers for the UART program loader:
//                frame start marker, FSM state encoding, frame layout and
//                instruction-word assembly.
//  Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    // Default frame start marker
    localparam logic [7:0] c_sync_byte = 8'hA5;

    // Frame layout: each instruction word arrives as W0, W1, W2
    localparam int c_bytes_per_word = 3;
    localparam int c_word_w         = 18;

    // FSM state encoding
    localparam int c_state_w = 3;
    localparam logic [c_state_w-1:0] c_st_idle    = 3'd0;
    localparam logic [c_state_w-1:0] c_st_addr_hi = 3'd1;
    localparam logic [c_state_w-1:0] c_st_addr_lo = 3'd2;
    localparam logic [c_state_w-1:0] c_st_count   = 3'd3;
    localparam logic [c_state_w-1:0] c_st_w0      = 3'd4;
    localparam logic [c_state_w-1:0] c_st_w1      = 3'd5;
    // Last payload byte of a word sits bytes_per_word-1 states after W0
    localparam logic [c_state_w-1:0] c_st_w2      =
        c_state_w'(c_st_w0 + c_bytes_per_word - 1);
    localparam logic [c_state_w-1:0] c_st_csum    = 3'd7;

    // Instruction word: W0[1:0] on top, then W1, then W2
    function automatic logic [c_word_w-1:0] assemble_word(
        input logic [1:0] b0,
        input logic [7:0] b1,
        input logic [7:0] b2
    );
        return {b0, b1, b2};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_timeout.sv
`default_nettype none
// ============================================================================
//  Module      : loader_timeout
//  Description : Inter-byte watchdog. Loadable down-counter: 'load' reloads
//                TIMEOUT_CYCLES-1, 'clear' zeroes it, 'en' counts down.
//                'expire' is high in the cycle the enabled count sits at zero
//                without a reload, i.e. TIMEOUT_CYCLES-1 cycles after the
//                last load.
//  Ports       : clk, rst (async, active-low), clear, load, en -> expire
//  Revision    : 1.0 - initial release
// ============================================================================
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_load_val = c_cnt_w'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Load wins over clear: the sync byte reloads the counter while the
    // parent FSM is still idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= c_load_val;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign expire = en && !load && (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : prog_loader
//  Description : UART-driven program loader for the 1024x18 program RAM.
//                Parses SYNC, ADDR_HI, ADDR_LO, COUNT, COUNT x (W0,W1,W2),
//                CSUM; writes one 18-bit word per triple and holds the CPU
//                in reset while loading. A bad checksum or inter-byte
//                timeout leaves cpu_reset asserted until a good frame.
//  Ports       : clk, rst (async, active-low)
//                rx_data[7:0], rx_valid          - byte stream from UART rx
//                wr_addr, wr_data[17:0], wr_en   - program RAM write port
//                cpu_reset, busy, done, err      - status / control
//  Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    // Supported range 9..16: ADDR_HI supplies the bits above bit 7
    parameter int         ADDR_WIDTH     = 10,
    parameter logic [7:0] SYNC_BYTE      = c_sync_byte,
    parameter int         TIMEOUT_CYCLES = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [c_word_w-1:0]   wr_data,
    output logic                  wr_en,
    output logic                  cpu_reset,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    logic [c_state_w-1:0]  r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_remaining;
    logic [7:0]            r_sum;
    logic [1:0]            r_w0;
    logic [7:0]            r_w1;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [c_word_w-1:0]   r_wr_data;
    logic                  r_wr_en;
    logic                  r_cpu_reset;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_in_frame;
    logic                  w_expire;
    logic [7:0]            w_sum_next;

    assign w_in_frame = (r_state != c_st_idle);
    assign w_sum_next = r_sum + rx_data;

    loader_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (!w_in_frame),
        .load   (rx_valid),
        .en     (w_in_frame),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_st_idle;
            r_addr      <= '0;
            r_remaining <= '0;
            r_sum       <= '0;
            r_w0        <= '0;
            r_w1        <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
            r_cpu_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;

            if (rx_valid) begin
                // Every byte after SYNC, CSUM included, feeds the sum
                if (w_in_frame) begin
                    r_sum <= w_sum_next;
                end

                case (r_state)
                    c_st_idle: begin
                        if (rx_data == SYNC_BYTE) begin
                            r_state     <= c_st_addr_hi;
                            r_sum       <= '0;
                            r_busy      <= 1'b1;
                            r_cpu_reset <= 1'b1;
                        end
                    end
                    c_st_addr_hi: begin
                        // Upper byte bits beyond the RAM size are only summed
                        r_addr[ADDR_WIDTH-1:8] <= rx_data[ADDR_WIDTH-9:0];
                        r_state                <= c_st_addr_lo;
                    end
                    c_st_addr_lo: begin
                        r_addr[7:0] <= rx_data;
                        r_state     <= c_st_count;
                    end
                    c_st_count: begin
                        r_remaining <= rx_data;
                        r_state     <= (rx_data == 8'd0) ? c_st_csum : c_st_w0;
                    end
                    c_st_w0: begin
                        r_w0    <= rx_data[1:0];
                        r_state <= c_st_w1;
                    end
                    c_st_w1: begin
                        r_w1    <= rx_data;
                        r_state <= c_st_w2;
                    end
                    c_st_w2: begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_addr;
                        r_wr_data   <= assemble_word(r_w0, r_w1, rx_data);
                        r_addr      <= r_addr + 1'b1;
                        r_remaining <= r_remaining - 8'd1;
                        r_state     <= (r_remaining == 8'd1) ? c_st_csum : c_st_w0;
                    end
                    c_st_csum: begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        if (w_sum_next == 8'd0) begin
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            // Halt stays asserted until a clean upload
                            r_err <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end else if (w_expire) begin
                // Abandon the frame; words already written stay in RAM
                r_state <= c_st_idle;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign wr_en     = r_wr_en;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Frames are built from
//                a word list; every W2 byte pushes the expected RAM write
//                onto a scoreboard queue, popped when wr_en is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    localparam int         c_addr_w  = 10;
    localparam int         c_timeout = 100;
    localparam logic [7:0] c_sync    = 8'hA5;

    logic                clk;
    logic                rst;
    logic [7:0]          rx_data;
    logic                rx_valid;
    logic [c_addr_w-1:0] wr_addr;
    logic [17:0]         wr_data;
    logic                wr_en;
    logic                cpu_reset;
    logic                busy;
    logic                done;
    logic                err;

    int checks;
    int errors;
    int n_wr;
    int n_done;
    int n_err;

    logic [27:0] exp_q[$];   // {addr, data}
    logic [23:0] wq[$];      // {W0, W1, W2}

    prog_loader #(
        .ADDR_WIDTH     (c_addr_w),
        .SYNC_BYTE      (c_sync),
        .TIMEOUT_CYCLES (c_timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle and sample 1 ns after the edge; writes are popped
    // against the scoreboard here.
    task automatic tick();
        logic [27:0] e;
        @(posedge clk);
        #1;
        if (wr_en) begin
            n_wr++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%h data=%h, none expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({wr_addr, wr_data} !== e) begin
                    errors++;
                    $display("FAIL ram_write got addr=%h data=%h expected addr=%h data=%h",
                             wr_addr, wr_data, e[27:18], e[17:0]);
                end
            end
        end
        if (done) n_done++;
        if (err)  n_err++;
    endtask

    // Idle for 'gap' cycles, then present one byte for one cycle. Returns
    // sampled just after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [9:0] start, input bit corrupt, input int gap);
        logic [7:0]  sum;
        logic [7:0]  hi;
        logic [7:0]  csum;
        logic [9:0]  a;
        logic [23:0] w;
        int          cnt;
        cnt = wq.size();
        sum = 8'd0;
        a   = start;
        send_byte(c_sync, gap);
        checks++;
        if (busy !== 1'b1 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL frame_start got busy=%b cpu_reset=%b expected 1 1", busy, cpu_reset);
        end
        hi = {6'($urandom), start[9:8]};
        send_byte(hi, gap);          sum = sum + hi;
        send_byte(start[7:0], gap);  sum = sum + start[7:0];
        send_byte(8'(cnt), gap);     sum = sum + 8'(cnt);
        for (int i = 0; i < cnt; i++) begin
            w = wq[i];
            send_byte(w[23:16], gap); sum = sum + w[23:16];
            send_byte(w[15:8], gap);  sum = sum + w[15:8];
            exp_q.push_back({a, w[17:0]});
            send_byte(w[7:0], gap);   sum = sum + w[7:0];
            checks++;
            if (wr_en !== 1'b1) begin
                errors++;
                $display("FAIL w2_latency got wr_en=%b expected 1 after word %0d", wr_en, i);
            end
            a = a + 10'd1;
        end
        csum = (8'h00 - sum) + (corrupt ? 8'd1 : 8'd0);
        send_byte(csum, gap);
        checks++;
        if (done !== !corrupt || err !== corrupt || busy !== 1'b0 || cpu_reset !== corrupt) begin
            errors++;
            $display("FAIL frame_end got done=%b err=%b busy=%b cpu_reset=%b expected %b %b 0 %b",
                     done, err, busy, cpu_reset, !corrupt, corrupt, corrupt);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        wq.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wr_en, done, err, busy, cpu_reset, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_state got en=%b done=%b err=%b busy=%b cpu=%b addr=%h data=%h expected all 0",
                     wr_en, done, err, busy, cpu_reset, wr_addr, wr_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        wq.push_back(24'h00C001);
        wq.push_back(24'h03400F);
        run_frame(10'h010, 1'b0, 1);
    endtask

    task automatic test_bad_then_good();
        int w0;
        w0 = n_wr;
        wq.push_back(24'h00C001);
        wq.push_back(24'h03400F);
        run_frame(10'h010, 1'b1, 1);
        checks++;
        if (n_wr - w0 != 2) begin
            errors++;
            $display("FAIL bad_frame_writes got %0d expected 2", n_wr - w0);
        end
        wq.push_back(24'($urandom));
        run_frame(10'h123, 1'b0, 2);
    endtask

    task automatic test_wrap();
        wq.push_back(24'($urandom));
        wq.push_back(24'($urandom));
        run_frame(10'h3FF, 1'b0, 1);
    endtask

    task automatic test_timeout();
        int k;
        int w0;
        w0 = n_wr;
        send_byte(c_sync, 1);
        send_byte(8'h00, 1);
        send_byte(8'h00, 1);
        k = 0;
        while (!err && k < 3 * c_timeout) begin
            tick();
            k++;
        end
        checks++;
        if (k != c_timeout) begin
            errors++;
            $display("FAIL timeout_cycle got err after %0d cycles expected %0d", k, c_timeout);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || cpu_reset !== 1'b1 || n_wr != w0) begin
            errors++;
            $display("FAIL timeout_state got busy=%b cpu_reset=%b writes=%0d expected 0 1 0",
                     busy, cpu_reset, n_wr - w0);
        end
        // A fresh frame must parse from IDLE and release the halt
        wq.push_back(24'($urandom));
        run_frame(10'h2A0, 1'b0, 0);
    endtask

    task automatic test_idle_noise_and_empty();
        logic [7:0] noise [3];
        int d0;
        int e0;
        noise = '{8'h00, 8'hFF, 8'h5A};
        d0 = n_done;
        e0 = n_err;
        for (int i = 0; i < 3; i++) begin
            send_byte(noise[i], 1);
            checks++;
            if (busy !== 1'b0 || cpu_reset !== 1'b0) begin
                errors++;
                $display("FAIL idle_noise got busy=%b cpu_reset=%b expected 0 0 byte %h",
                         busy, cpu_reset, noise[i]);
            end
        end
        repeat (3) tick();
        checks++;
        if (n_done != d0 || n_err != e0) begin
            errors++;
            $display("FAIL idle_noise_pulses got done=%0d err=%0d expected 0 0", n_done - d0, n_err - e0);
        end
        run_frame(10'h000, 1'b0, 1);
    endtask

    task automatic test_reset_mid_frame();
        int w0;
        send_byte(c_sync, 1);
        send_byte(8'h00, 1);
        send_byte(8'h05, 1);
        send_byte(8'h01, 1);
        send_byte(8'hAA, 1);
        send_byte(8'hBB, 1);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({wr_en, done, err, busy, cpu_reset, wr_addr, wr_data} !== '0) begin
            errors++;
            $display("FAIL async_reset got en=%b done=%b err=%b busy=%b cpu=%b addr=%h data=%h expected all 0",
                     wr_en, done, err, busy, cpu_reset, wr_addr, wr_data);
        end
        #2;
        rst = 1'b1;
        w0 = n_wr;
        send_byte(8'hCC, 1);
        repeat (4) tick();
        checks++;
        if (n_wr != w0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got writes=%0d busy=%b expected 0 0", n_wr - w0, busy);
        end
        wq.push_back(24'h02A5A5);
        run_frame(10'h005, 1'b0, 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) wq.push_back(24'($urandom));
        run_frame(10'h0F0, 1'b0, 0);
        for (int i = 0; i < 4; i++) wq.push_back(24'($urandom));
        run_frame(10'h1FE, 1'b0, 0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        n_wr     = 0;
        n_done   = 0;
        n_err    = 0;
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_good_frame();
        test_bad_then_good();
        test_wrap();
        test_timeout();
        test_idle_noise_and_empty();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
